// File: rtl/mem_defines_pkg.sv
// Shared types and constants for mem_sys_arbiter.
// States, owner encoding, the latched request record and the watchdog defaults.
package mem_defines;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } arb_owner_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        wr;
        logic        rd;
        logic [3:0]  be;
    } arb_req_t;

    localparam int unsigned MEM_ARB_TIMEOUT_DEFAULT = 100;
    localparam logic [31:0] TIMEOUT_PATTERN         = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_sys_arbiter.sv
// Two-requester round-robin arbiter in front of mem_sys_axil_wrapper.
// Optional mem_done watchdog is built only when MEM_ARB_TIMEOUT_EN is defined.
module mem_sys_arbiter
    import mem_defines::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = MEM_ARB_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_data_in,
    input  logic        m0_wr,
    input  logic        m0_rd,
    input  logic        m0_valid,
    input  logic [3:0]  m0_be,
    output logic [31:0] m0_data_out,
    output logic        m0_done,

    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_data_in,
    input  logic        m1_wr,
    input  logic        m1_rd,
    input  logic        m1_valid,
    input  logic [3:0]  m1_be,
    output logic [31:0] m1_data_out,
    output logic        m1_done,

    output logic [31:0] mem_addr,
    output logic [31:0] mem_data_in,
    output logic        mem_wr,
    output logic        mem_rd,
    output logic        mem_valid,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_data_out,
    input  logic        mem_done,

    output logic        timeout_err
);

    arb_state_t  state_q, state_d;
    arb_owner_t  owner_q, owner_d;
    arb_owner_t  rr_q, rr_d;
    arb_req_t    req_q, req_d;
    logic        mem_valid_q, mem_valid_d;
    logic [31:0] m0_data_out_q, m0_data_out_d;
    logic [31:0] m1_data_out_q, m1_data_out_d;
    logic        m0_done_q, m0_done_d;
    logic        m1_done_q, m1_done_d;

    logic        legal0, legal1;
    logic        owner_valid, other_legal;
    arb_owner_t  other_owner;
    arb_req_t    m0_req, m1_req;
    logic        grant_en, finish_en;
    arb_owner_t  grant_owner;
    logic [31:0] finish_data;
    logic        wd_expired;

    assign legal0 = m0_valid & (m0_rd ^ m0_wr);
    assign legal1 = m1_valid & (m1_rd ^ m1_wr);

    assign m0_req = '{addr: m0_addr, data: m0_data_in, wr: m0_wr, rd: m0_rd, be: m0_be};
    assign m1_req = '{addr: m1_addr, data: m1_data_in, wr: m1_wr, rd: m1_rd, be: m1_be};

    assign owner_valid = (owner_q == M0) ? m0_valid : m1_valid;
    assign other_owner = (owner_q == M0) ? M1 : M0;
    assign other_legal = (owner_q == M0) ? legal1 : legal0;

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        rr_d          = rr_q;
        req_d         = req_q;
        mem_valid_d   = mem_valid_q;
        m0_data_out_d = m0_data_out_q;
        m1_data_out_d = m1_data_out_q;
        m0_done_d     = 1'b0;
        m1_done_d     = 1'b0;
        grant_en      = 1'b0;
        grant_owner   = rr_q;
        finish_en     = 1'b0;
        finish_data   = mem_data_out;

        unique case (state_q)
            IDLE: begin
                if (legal0 || legal1) begin
                    grant_en    = 1'b1;
                    grant_owner = (legal0 && legal1) ? rr_q : (legal1 ? M1 : M0);
                end
            end
            BUSY: begin
                // A real completion wins over a watchdog expiry in the same cycle.
                if (mem_done) begin
                    finish_en = 1'b1;
                end else if (wd_expired) begin
                    finish_en   = 1'b1;
                    finish_data = TIMEOUT_PATTERN;
                end
            end
            RELEASE: begin
                if (!owner_valid) begin
                    if (other_legal) begin
                        grant_en    = 1'b1;
                        grant_owner = other_owner;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (finish_en) begin
            state_d     = RELEASE;
            mem_valid_d = 1'b0;
            req_d.rd    = 1'b0;
            req_d.wr    = 1'b0;
            if (owner_q == M0) begin
                m0_done_d     = 1'b1;
                m0_data_out_d = finish_data;
            end else begin
                m1_done_d     = 1'b1;
                m1_data_out_d = finish_data;
            end
        end

        if (grant_en) begin
            state_d     = BUSY;
            owner_d     = grant_owner;
            req_d       = (grant_owner == M0) ? m0_req : m1_req;
            mem_valid_d = 1'b1;
            rr_d        = (grant_owner == M0) ? M1 : M0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            owner_q       <= M0;
            rr_q          <= M0;
            req_q         <= '0;
            mem_valid_q   <= 1'b0;
            m0_data_out_q <= '0;
            m1_data_out_q <= '0;
            m0_done_q     <= 1'b0;
            m1_done_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            rr_q          <= rr_d;
            req_q         <= req_d;
            mem_valid_q   <= mem_valid_d;
            m0_data_out_q <= m0_data_out_d;
            m1_data_out_q <= m1_data_out_d;
            m0_done_q     <= m0_done_d;
            m1_done_q     <= m1_done_d;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [15:0] WdLimit = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wd_cnt_q, wd_cnt_d;
    logic        timeout_err_q, timeout_err_d;

    // Expiry fires at the end of the TIMEOUT_CYCLES-th BUSY cycle.
    assign wd_expired = (state_q == BUSY) && (wd_cnt_q == WdLimit);

    always_comb begin
        wd_cnt_d      = '0;
        timeout_err_d = timeout_err_q;
        if (state_q == BUSY && !mem_done && !wd_expired) begin
            wd_cnt_d = wd_cnt_q + 16'd1;
        end
        if (wd_expired && !mem_done) begin
            timeout_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wd_cnt_q      <= wd_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    // Parameter is only meaningful with the watchdog built; keep it referenced.
    logic [31:0] unused_timeout_cfg;
    assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
    assign wd_expired         = 1'b0;
    assign timeout_err        = 1'b0;
`endif

    assign mem_addr    = req_q.addr;
    assign mem_data_in = req_q.data;
    assign mem_wr      = req_q.wr;
    assign mem_rd      = req_q.rd;
    assign mem_be      = req_q.be;
    assign mem_valid   = mem_valid_q;
    assign m0_data_out = m0_data_out_q;
    assign m1_data_out = m1_data_out_q;
    assign m0_done     = m0_done_q;
    assign m1_done     = m1_done_q;

endmodule

// File: tb/tb_mem_sys_arbiter.sv
// Directed bench for mem_sys_arbiter: small memory responder, grant/done monitor,
// one task per scenario. Watchdog expectations follow MEM_ARB_TIMEOUT_EN.
module tb_mem_sys_arbiter;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] m0_addr, m0_data_in, m0_data_out;
    logic        m0_wr, m0_rd, m0_valid, m0_done;
    logic [3:0]  m0_be;
    logic [31:0] m1_addr, m1_data_in, m1_data_out;
    logic        m1_wr, m1_rd, m1_valid, m1_done;
    logic [3:0]  m1_be;
    logic [31:0] mem_addr, mem_data_in, mem_data_out;
    logic        mem_wr, mem_rd, mem_valid, mem_done;
    logic [3:0]  mem_be;
    logic        timeout_err;

    logic        resp_en, resp_done, inj_done;
    int          wait_cnt;
    logic [31:0] mem_model [32];

    logic [31:0] grant_log [64];
    int          grant_cnt, m0_done_cnt, m1_done_cnt;
    logic        prev_valid;

    int tests, fails;

    always #5 clk = ~clk;

    assign mem_done = resp_done | inj_done;

    mem_sys_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_addr(m0_addr), .m0_data_in(m0_data_in), .m0_wr(m0_wr), .m0_rd(m0_rd),
        .m0_valid(m0_valid), .m0_be(m0_be), .m0_data_out(m0_data_out), .m0_done(m0_done),
        .m1_addr(m1_addr), .m1_data_in(m1_data_in), .m1_wr(m1_wr), .m1_rd(m1_rd),
        .m1_valid(m1_valid), .m1_be(m1_be), .m1_data_out(m1_data_out), .m1_done(m1_done),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_wr(mem_wr), .mem_rd(mem_rd),
        .mem_valid(mem_valid), .mem_be(mem_be), .mem_data_out(mem_data_out),
        .mem_done(mem_done), .timeout_err(timeout_err)
    );

    // Memory responder: completes a request on its third mem_valid cycle.
    initial begin
        resp_done    = 1'b0;
        mem_data_out = '0;
        wait_cnt     = 0;
        for (int i = 0; i < 32; i++) mem_model[i] = '0;
        mem_model[0]  = 32'hA5A5_0001;
        mem_model[8]  = 32'h0000_0808;
        mem_model[12] = 32'h0000_0C0C;
        forever begin
            @(negedge clk);
            resp_done = 1'b0;
            if (resp_en && mem_valid) begin
                if (wait_cnt == 2) begin
                    resp_done = 1'b1;
                    wait_cnt  = 0;
                    if (mem_wr) begin
                        for (int b = 0; b < 4; b++)
                            if (mem_be[b]) mem_model[mem_addr[4:0]][8*b +: 8] = mem_data_in[8*b +: 8];
                    end else begin
                        mem_data_out = mem_model[mem_addr[4:0]];
                    end
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    initial begin
        grant_cnt   = 0;
        m0_done_cnt = 0;
        m1_done_cnt = 0;
        prev_valid  = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_valid === 1'b1 && prev_valid !== 1'b1 && grant_cnt < 64) begin
                grant_log[grant_cnt] = mem_addr;
                grant_cnt++;
            end
            prev_valid = mem_valid;
            if (m0_done === 1'b1) m0_done_cnt++;
            if (m1_done === 1'b1) m1_done_cnt++;
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic set_m0(input logic v, input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d);
        m0_valid = v; m0_rd = rd; m0_wr = wr; m0_addr = a; m0_data_in = d; m0_be = 4'hF;
    endtask

    task automatic set_m1(input logic v, input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] be);
        m1_valid = v; m1_rd = rd; m1_wr = wr; m1_addr = a; m1_data_in = d; m1_be = be;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_m0(1'b0, 1'b0, 1'b0, '0, '0);
        set_m1(1'b0, 1'b0, 1'b0, '0, '0, 4'h0);
        inj_done = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic wait_done(input int which, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if ((which == 0 && m0_done === 1'b1) || (which == 1 && m1_done === 1'b1)) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
    endtask

    task automatic wait_mem_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (mem_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (mem_valid !== 1'b0 || mem_rd !== 1'b0 || mem_wr !== 1'b0) begin
            fails++; $display("FAIL reset_mem_ctl: valid/rd/wr=%b%b%b want 000", mem_valid, mem_rd, mem_wr);
        end
        tests++; if (mem_addr !== 32'h0 || mem_data_in !== 32'h0 || mem_be !== 4'h0) begin
            fails++; $display("FAIL reset_mem_bus: addr=%h data=%h be=%h want 0", mem_addr, mem_data_in, mem_be);
        end
        tests++; if (m0_done !== 1'b0 || m1_done !== 1'b0) begin
            fails++; $display("FAIL reset_done: m0=%b m1=%b want 0", m0_done, m1_done);
        end
        tests++; if (m0_data_out !== 32'h0 || m1_data_out !== 32'h0) begin
            fails++; $display("FAIL reset_data_out: m0=%h m1=%h want 0", m0_data_out, m1_data_out);
        end
        tests++; if (timeout_err !== 1'b0) begin
            fails++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err);
        end
    endtask

    task automatic test_write_read();
        bit ok;
        int d0, d1;
        d0 = m0_done_cnt; d1 = m1_done_cnt;
        set_m1(1'b1, 1'b0, 1'b1, 32'h10, 32'h1234_5678, 4'hF);
        wait_done(1, ok);
        m1_valid = 1'b0;
        tests++; if (!ok) begin fails++; $display("FAIL wr_done_seen: got 0 want 1"); end
        cyc(); cyc();
        tests++; if (m1_done_cnt - d1 != 1) begin
            fails++; $display("FAIL wr_done_count: got %0d want 1", m1_done_cnt - d1);
        end
        set_m1(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
        wait_done(1, ok);
        m1_valid = 1'b0;
        tests++; if (!ok || m1_data_out !== 32'h1234_5678) begin
            fails++; $display("FAIL rd_data: got %h want 12345678 (done seen %0d)", m1_data_out, ok);
        end
        cyc(); cyc();
        tests++; if (m1_done_cnt - d1 != 2 || m0_done_cnt - d0 != 0) begin
            fails++; $display("FAIL wr_rd_done_counts: m1=%0d m0=%0d want 2 0",
                              m1_done_cnt - d1, m0_done_cnt - d0);
        end
    endtask

    task automatic test_contention();
        bit ok;
        int g, d0, d1;
        do_reset();
        g = grant_cnt; d0 = m0_done_cnt; d1 = m1_done_cnt;
        set_m0(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
        set_m1(1'b1, 1'b0, 1'b1, 32'h4, 32'hCAFE_0004, 4'hF);
        wait_done(0, ok);
        m0_valid = 1'b0;
        tests++; if (!ok || m0_data_out !== 32'hA5A5_0001 || m1_done_cnt != d1) begin
            fails++; $display("FAIL tie_m0_first: ok=%0d data=%h m1_dones=%0d want 1 a5a50001 0",
                              ok, m0_data_out, m1_done_cnt - d1);
        end
        cyc();
        tests++; if (mem_valid !== 1'b1 || mem_addr !== 32'h4 || mem_wr !== 1'b1) begin
            fails++; $display("FAIL no_bubble: valid=%b addr=%h wr=%b want 1 00000004 1",
                              mem_valid, mem_addr, mem_wr);
        end
        wait_done(1, ok);
        m1_valid = 1'b0;
        cyc(); cyc();
        tests++; if (!ok || grant_cnt - g != 2 || grant_log[g] !== 32'h0 || grant_log[g+1] !== 32'h4) begin
            fails++; $display("FAIL tie_grant_order: n=%0d first=%h second=%h want 2 0 4",
                              grant_cnt - g, grant_log[g], grant_log[g+1]);
        end
        tests++; if (m0_done_cnt - d0 != 1 || m1_done_cnt - d1 != 1) begin
            fails++; $display("FAIL tie_done_counts: m0=%0d m1=%0d want 1 1",
                              m0_done_cnt - d0, m1_done_cnt - d1);
        end
    endtask

    task automatic test_round_robin();
        bit ok, got0, got1;
        int g;
        logic [31:0] want;
        set_m0(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
        wait_done(0, ok);
        m0_valid = 1'b0;
        cyc(); cyc();
        g = grant_cnt;
        for (int r = 0; r < 4; r++) begin
            set_m0(1'b1, 1'b1, 1'b0, 32'h8, 32'h0);
            set_m1(1'b1, 1'b1, 1'b0, 32'hC, 32'h0, 4'hF);
            got0 = 1'b0; got1 = 1'b0;
            for (int i = 0; i < 100 && !(got0 && got1); i++) begin
                if (m0_done === 1'b1) begin m0_valid = 1'b0; got0 = 1'b1; end
                if (m1_done === 1'b1) begin m1_valid = 1'b0; got1 = 1'b1; end
                cyc();
            end
            tests++; if (!(got0 && got1)) begin
                fails++; $display("FAIL rr_round%0d_done: m0=%0d m1=%0d want 1 1", r, got0, got1);
            end
            cyc();
        end
        tests++; if (grant_cnt - g != 8) begin
            fails++; $display("FAIL rr_grant_count: got %0d want 8", grant_cnt - g);
        end
        for (int k = 0; k < 8; k++) begin
            want = (k % 2 == 0) ? 32'hC : 32'h8;
            tests++; if (grant_log[g+k] !== want) begin
                fails++; $display("FAIL rr_grant%0d: got %h want %h", k, grant_log[g+k], want);
            end
        end
    endtask

    task automatic test_hold_valid();
        bit ok;
        int g, d0, bad;
        g = grant_cnt; d0 = m0_done_cnt; bad = 0;
        set_m0(1'b1, 1'b1, 1'b0, 32'h8, 32'h0);
        wait_done(0, ok);
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (mem_valid !== 1'b0 || m0_done !== 1'b0) bad++;
        end
        m0_valid = 1'b0;
        cyc(); cyc(); cyc();
        tests++; if (!ok || bad != 0 || m0_data_out !== 32'h0000_0808) begin
            fails++; $display("FAIL hold_no_regrant: ok=%0d bad_cycles=%0d data=%h want 1 0 00000808",
                              ok, bad, m0_data_out);
        end
        tests++; if (grant_cnt - g != 1 || m0_done_cnt - d0 != 1) begin
            fails++; $display("FAIL hold_single_txn: grants=%0d dones=%0d want 1 1",
                              grant_cnt - g, m0_done_cnt - d0);
        end
    endtask

    task automatic test_busy_isolation();
        bit ok;
        int d0, d1, bad;
        resp_en = 1'b0;
        set_m1(1'b1, 1'b0, 1'b1, 32'h14, 32'h1111_2222, 4'h3);
        wait_mem_valid(ok);
        set_m1(1'b1, 1'b1, 1'b0, 32'h3F, 32'hFFFF_0000, 4'hC);
        cyc(); cyc();
        tests++; if (!ok || mem_addr !== 32'h14 || mem_data_in !== 32'h1111_2222 || mem_be !== 4'h3
                     || mem_wr !== 1'b1 || mem_rd !== 1'b0 || mem_valid !== 1'b1) begin
            fails++; $display("FAIL busy_latched: addr=%h data=%h be=%h wr=%b rd=%b valid=%b",
                              mem_addr, mem_data_in, mem_be, mem_wr, mem_rd, mem_valid);
        end
        inj_done = 1'b1;
        cyc();
        inj_done = 1'b0;
        tests++; if (m1_done !== 1'b1 || m0_done !== 1'b0 || mem_valid !== 1'b0) begin
            fails++; $display("FAIL manual_done: m1=%b m0=%b valid=%b want 1 0 0",
                              m1_done, m0_done, mem_valid);
        end
        m1_valid = 1'b0;
        cyc(); cyc();
        d0 = m0_done_cnt; d1 = m1_done_cnt; bad = 0;
        inj_done = 1'b1;
        cyc();
        inj_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (mem_valid !== 1'b0) bad++;
        end
        tests++; if (m0_done_cnt != d0 || m1_done_cnt != d1 || bad != 0) begin
            fails++; $display("FAIL stray_done_idle: m0=%0d m1=%0d valid_cycles=%0d want 0 0 0",
                              m0_done_cnt - d0, m1_done_cnt - d1, bad);
        end
        resp_en = 1'b1;
    endtask

    task automatic test_reset_mid_busy();
        bit ok;
        int d0, d1, bad;
        resp_en = 1'b0;
        set_m0(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
        wait_mem_valid(ok);
        cyc();
        rst_n = 1'b0;
        m0_valid = 1'b0;
        cyc();
        rst_n = 1'b1;
        d0 = m0_done_cnt; d1 = m1_done_cnt; bad = 0;
        inj_done = 1'b1;
        cyc();
        inj_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (mem_valid !== 1'b0 || m0_done !== 1'b0 || m1_done !== 1'b0) bad++;
        end
        tests++; if (!ok || bad != 0 || m0_done_cnt != d0 || m1_done_cnt != d1) begin
            fails++; $display("FAIL rst_busy_silent: ok=%0d bad=%0d dones=%0d/%0d want 1 0 0/0",
                              ok, bad, m0_done_cnt - d0, m1_done_cnt - d1);
        end
        tests++; if (mem_addr !== 32'h0 || mem_be !== 4'h0 || m0_data_out !== 32'h0
                     || m1_data_out !== 32'h0 || timeout_err !== 1'b0) begin
            fails++; $display("FAIL rst_busy_values: addr=%h be=%h d0=%h d1=%h te=%b want all 0",
                              mem_addr, mem_be, m0_data_out, m1_data_out, timeout_err);
        end
        resp_en = 1'b1;
    endtask

    task automatic test_timeout();
        bit ok;
        int done_at;
        logic valid8, te;
        logic [31:0] dout;
        resp_en = 1'b0;
        done_at = -1; valid8 = 1'b0; te = 1'b0; dout = '0;
        set_m1(1'b1, 1'b1, 1'b0, 32'h18, 32'h0, 4'hF);
        wait_mem_valid(ok);
        for (int i = 2; i <= 20; i++) begin
            cyc();
            if (i == 8) valid8 = mem_valid;
            if (m1_done === 1'b1 && done_at < 0) begin
                done_at = i; dout = m1_data_out; te = timeout_err;
            end
        end
`ifdef MEM_ARB_TIMEOUT_EN
        tests++; if (!ok || done_at != 9 || valid8 !== 1'b1) begin
            fails++; $display("FAIL to_done_cycle: got %0d (valid8=%b) want 9 (1)", done_at, valid8);
        end
        tests++; if (dout !== 32'hDEAD_BEEF || te !== 1'b1) begin
            fails++; $display("FAIL to_pattern: data=%h err=%b want deadbeef 1", dout, te);
        end
        m1_valid = 1'b0;
        cyc(); cyc(); cyc();
        tests++; if (timeout_err !== 1'b1 || mem_valid !== 1'b0) begin
            fails++; $display("FAIL to_sticky: err=%b valid=%b want 1 0", timeout_err, mem_valid);
        end
        do_reset();
        tests++; if (timeout_err !== 1'b0) begin
            fails++; $display("FAIL to_cleared: err=%b want 0", timeout_err);
        end
`else
        tests++; if (!ok || done_at != -1 || mem_valid !== 1'b1) begin
            fails++; $display("FAIL nto_waits: done_at=%0d valid=%b want -1 1", done_at, mem_valid);
        end
        tests++; if (timeout_err !== 1'b0 || te !== 1'b0) begin
            fails++; $display("FAIL nto_err: err=%b want 0", timeout_err);
        end
        m1_valid = 1'b0;
        do_reset();
`endif
        resp_en = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        tests    = 0;
        fails    = 0;
        resp_en  = 1'b1;
        inj_done = 1'b0;
        rst_n    = 1'b0;
        test_reset();
        test_write_read();
        test_contention();
        test_round_robin();
        test_hold_valid();
        test_busy_isolation();
        test_reset_mid_busy();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_sys_arbiter.md
MEM_SYS_ARBITER -- requirements
Module: mem_sys_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 100, mem_done wait limit in clk cycles; legal range 2..65535.
REQ-002 Port: clk, input, 1, sole clock, rising edge.
REQ-003 Port: rst_n, input, 1, reset, synchronous and active-low.
REQ-004 Ports m0_addr/m1_addr, input, 32, requester word address (m0 = instruction fetch, m1 = data).
REQ-005 Ports m0_data_in/m1_data_in, input, 32, write data.
REQ-006 Ports m0_wr, m0_rd, m0_valid, m1_wr, m1_rd, m1_valid, input, 1 each, request qualifiers.
REQ-007 Ports m0_be/m1_be, input, 4, byte enables.
REQ-008 Ports m0_data_out/m1_data_out, output, 32, read data; m0_done/m1_done, output, 1, completion pulse.
REQ-009 Ports mem_addr, mem_data_in (output, 32), mem_wr, mem_rd, mem_valid (output, 1), mem_be (output, 4): downstream request to mem_sys_axil_wrapper.
REQ-010 Ports mem_data_out (input, 32) and mem_done (input, 1): downstream response.
REQ-011 Port timeout_err, output, 1, sticky watchdog flag.

Function
REQ-012 A request is legal when valid=1 and exactly one of rd/wr is 1; otherwise it is ignored and never granted.
REQ-013 FSM states: IDLE, BUSY, RELEASE.
REQ-014 IDLE: a legal request grants on the next edge, goes to BUSY and latches the owner's addr, data_in, wr, rd and be.
REQ-015 Both requesters legal in the same cycle: grant goes to the requester not served last (round-robin); m0 wins the first tie after reset.
REQ-016 BUSY: mem_valid=1 and latched fields are driven unchanged until the cycle mem_done is sampled high.
REQ-017 On mem_done: next edge sets mem_valid=0, mem_rd=0, mem_wr=0, pulses the owner's done for exactly 1 cycle, registers mem_data_out into the owner's data_out, and enters RELEASE.
REQ-018 Requester latency: done is 1 cycle after mem_done; grant-to-mem_valid is 1 cycle after the request is sampled.
REQ-019 RELEASE: hold until the owner's valid is sampled 0, then IDLE; the same transaction is never serviced twice.
REQ-020 RELEASE: a pending request from the other requester goes straight to BUSY instead of IDLE (no idle bubble).
REQ-021 Non-owner done is 0 at all times; a non-owner's data_out holds its last value.
REQ-022 Requester inputs changing during BUSY have no effect on mem_* outputs.
REQ-023 mem_done seen outside BUSY is ignored.

Reset
REQ-024 rst_n=0 at a clk edge forces IDLE, mem_valid/mem_rd/mem_wr=0, mem_addr/mem_data_in=0, mem_be=0, m0/m1_done=0, m0/m1_data_out=0, timeout_err=0, round-robin pointer to "m0 next", and watchdog count=0.
REQ-025 Reset mid-BUSY abandons the transaction silently: no done pulse, and no action on a later stray mem_done.

Configuration
REQ-026 With MEM_ARB_TIMEOUT_EN defined: a counter runs in BUSY; when TIMEOUT_CYCLES elapse without mem_done, mem_valid drops, the owner gets a done pulse with data_out=32'hDEAD_BEEF, timeout_err sets until reset, and the FSM enters RELEASE.
REQ-027 Without MEM_ARB_TIMEOUT_EN: no counter is built, BUSY waits indefinitely, and timeout_err is tied 0.

Structure
REQ-028 mem_defines holds arb_state_t (IDLE/BUSY/RELEASE), arb_owner_t (M0/M1), MEM_ARB_TIMEOUT_DEFAULT=100 and TIMEOUT_PATTERN=32'hDEAD_BEEF.
REQ-029 No sub-module: FSM, round-robin pointer, request latch and watchdog are single-module logic.

Verification
REQ-030 m1 write addr 0x10, data 0x1234_5678, then read addr 0x10 -> m1_done pulses once per access, m1_data_out=0x1234_5678, m0_done stays 0.
REQ-031 m0 read 0x0 and m1 write 0x4 in the same cycle after reset -> m0 granted first, m1 mem_valid follows with no IDLE cycle between, and each done pulses once.
REQ-032 Repeat the same-cycle contention 4 times -> grants alternate m1,m0,m1,m0, with no starvation.
REQ-033 m0 holds valid 5 cycles after done -> m0 is not re-granted until valid=0, and exactly one mem_valid transaction is seen.
REQ-034 Assert rst_n=0 for 1 cycle mid-BUSY, then inject mem_done -> all outputs are at reset values and no done pulse occurs.
REQ-035 With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, mem_done never asserted -> owner done occurs on the 9th BUSY cycle with data_out=0xDEAD_BEEF and timeout_err=1 until reset; without the macro the same stimulus produces no done and timeout_err=0.
